// File: rtl/hazard_scoreboard.sv
// Register scoreboard with countdown timers that stalls ID on RAW hazards.
// Define HAZARD_FORWARD_EN for per-type latencies; default uses WB_STALL.
module hazard_scoreboard #(
  parameter int REG_AW     = 5,
  parameter int LOAD_STALL = 1,
  parameter int ALU_STALL  = 0,
  parameter int WB_STALL   = 2,
  parameter int CNT_W      = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     idValidIn,
  input  logic [REG_AW-1:0]        IFIDrs1In,
  input  logic [REG_AW-1:0]        IFIDrs2In,
  input  logic                     useRs1In,
  input  logic                     useRs2In,
  input  logic [REG_AW-1:0]        IFIDrdIn,
  input  logic                     IFIDRegWriteIn,
  input  logic                     IFIDMemReadIn,
  input  logic                     flushIn,
  input  logic                     mcBusyIn,
  output logic                     stallOut,
  output logic                     issueOut,
  output logic [(1<<REG_AW)-1:0]   pendingOut,
  output logic [CNT_W-1:0]         stallCntOut
);

  localparam int NREG = 1 << REG_AW;
  localparam int MAXA = (LOAD_STALL > ALU_STALL) ? LOAD_STALL : ALU_STALL;
  localparam int MAXL = (MAXA > WB_STALL) ? MAXA : WB_STALL;
  localparam int CW   = (MAXL < 1) ? 1 : $clog2(MAXL + 1);

`ifdef HAZARD_FORWARD_EN
  localparam int LD_LAT  = LOAD_STALL;
  localparam int ALU_LAT = ALU_STALL;
`else
  localparam int LD_LAT  = WB_STALL;
  localparam int ALU_LAT = WB_STALL;
`endif

  logic [CW-1:0] cnt [NREG];
  logic          hz1;
  logic          hz2;
  logic [CW-1:0] lat;
  logic          wrEn;

  assign hz1 = useRs1In && (IFIDrs1In != '0) && (cnt[IFIDrs1In] != '0);
  assign hz2 = useRs2In && (IFIDrs2In != '0) && (cnt[IFIDrs2In] != '0);

  assign stallOut = mcBusyIn | (idValidIn & ~flushIn & (hz1 | hz2));
  assign issueOut = idValidIn & ~flushIn & ~stallOut;

  assign lat  = IFIDMemReadIn ? CW'(LD_LAT) : CW'(ALU_LAT);
  // Zero latency must not disturb an older count still draining.
  assign wrEn = issueOut & IFIDRegWriteIn &
                (IFIDrdIn != '0) & (lat != '0);

  always_comb begin
    pendingOut = '0;
    for (int r = 0; r < NREG; r++) begin
      pendingOut[r] = (cnt[r] != '0);
    end
  end

  // Entry 0 is never loaded, so x0 can never look pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) begin
        cnt[r] <= '0;
      end
    end else if (!mcBusyIn) begin
      for (int r = 1; r < NREG; r++) begin
        if (wrEn && (IFIDrdIn == REG_AW'(r))) begin
          cnt[r] <= lat;
        end else if (cnt[r] != '0) begin
          cnt[r] <= cnt[r] - CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stallCntOut <= '0;
    end else if (stallOut && (stallCntOut != '1)) begin
      stallCntOut <= stallCntOut + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: ready-time model plus directed vectors.
// Works for both HAZARD_FORWARD_EN builds.
module tb_hazard_scoreboard;

  localparam int REG_AW = 5;
  localparam int CNT_W  = 16;
  localparam int NREG   = 32;
  localparam longint SATV = 65535;
`ifdef HAZARD_FORWARD_EN
  localparam int LAT_LD  = 1;
  localparam int LAT_ALU = 0;
`else
  localparam int LAT_LD  = 2;
  localparam int LAT_ALU = 2;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              idValid;
  logic [REG_AW-1:0] rs1;
  logic [REG_AW-1:0] rs2;
  logic              useRs1;
  logic              useRs2;
  logic [REG_AW-1:0] rd;
  logic              regWrite;
  logic              memRead;
  logic              flush;
  logic              mcBusy;
  logic              stallOut;
  logic              issueOut;
  logic [NREG-1:0]   pendingOut;
  logic [CNT_W-1:0]  stallCntOut;

  int vectors = 0;
  int miscompares = 0;

  int     activeEdges = 0;
  int     readyAt [NREG] = '{default: 0};
  longint statEdges = 0;

  hazard_scoreboard #(
    .REG_AW(REG_AW), .LOAD_STALL(1), .ALU_STALL(0),
    .WB_STALL(2), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .idValidIn(idValid),
    .IFIDrs1In(rs1), .IFIDrs2In(rs2),
    .useRs1In(useRs1), .useRs2In(useRs2),
    .IFIDrdIn(rd), .IFIDRegWriteIn(regWrite),
    .IFIDMemReadIn(memRead), .flushIn(flush),
    .mcBusyIn(mcBusy), .stallOut(stallOut),
    .issueOut(issueOut), .pendingOut(pendingOut),
    .stallCntOut(stallCntOut)
  );

  always #5 clk = ~clk;

  // A register is busy until the active-edge clock reaches its ready time.
  function automatic logic pendM(int r);
    return (r != 0) && (readyAt[r] > activeEdges);
  endfunction

  function automatic logic [NREG-1:0] maskM();
    logic [NREG-1:0] m;
    m = '0;
    for (int r = 0; r < NREG; r++) m[r] = pendM(r);
    return m;
  endfunction

  function automatic logic stallM();
    logic h;
    h = (useRs1 && pendM(int'(rs1))) || (useRs2 && pendM(int'(rs2)));
    return mcBusy || (idValid && !flush && h);
  endfunction

  function automatic logic issueM();
    return idValid && !flush && !stallM();
  endfunction

  function automatic int latM();
    return memRead ? LAT_LD : LAT_ALU;
  endfunction

  function automatic longint cntM();
    return (statEdges > SATV) ? SATV : statEdges;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      activeEdges <= 0;
      for (int r = 0; r < NREG; r++) readyAt[r] <= 0;
      statEdges <= 0;
    end else begin
      if (stallM()) statEdges <= statEdges + 1;
      if (!mcBusy) begin
        activeEdges <= activeEdges + 1;
        if (issueM() && regWrite && rd != 0 && latM() != 0)
          readyAt[rd] <= activeEdges + 1 + latM();
      end
    end
  end

  task automatic chk(string name, longint got, longint exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("m_stall", longint'(stallOut), longint'(stallM()));
    chk("m_issue", longint'(issueOut), longint'(issueM()));
    chk("m_pend", longint'(pendingOut), longint'(maskM()));
    chk("m_cnt", longint'(stallCntOut), cntM());
  end

  task automatic idle();
    idValid = 0; rs1 = 0; rs2 = 0; useRs1 = 0; useRs2 = 0;
    rd = 0; regWrite = 0; memRead = 0; flush = 0; mcBusy = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic issueOp(int dst, bit isLoad, string name);
    idle();
    idValid = 1; regWrite = 1; rd = dst[REG_AW-1:0]; memRead = isLoad;
    @(negedge clk); #1;
    chk({name, "_issue"}, longint'(issueOut), 1);
    tick();
    idle();
  endtask

  task automatic consumer(int src, int expStalls, string name);
    int n;
    bit done;
    n = 0;
    done = 0;
    idle();
    idValid = 1; useRs1 = 1; rs1 = src[REG_AW-1:0];
    useRs2 = 1; rs2 = 5'd1;
    for (int i = 0; i < 10 && !done; i++) begin
      @(negedge clk); #1;
      if (issueOut) done = 1;
      else n++;
      tick();
    end
    idle();
    chk({name, "_done"}, longint'(done), 1);
    chk({name, "_stalls"}, n, expStalls);
  endtask

  initial begin
    rst_n = 0;
    idle();
    #2;
    chk("rst_stall", longint'(stallOut), 0);
    chk("rst_issue", longint'(issueOut), 0);
    chk("rst_pend", longint'(pendingOut), 0);
    chk("rst_cnt", longint'(stallCntOut), 0);
    tick();
    rst_n = 1;
    tick();

    issueOp(7, 0, "add7");
    chk("add7_pend", longint'(pendingOut[7]), longint'(LAT_ALU != 0));
    consumer(7, LAT_ALU, "use7");
    chk("use7_cnt", longint'(stallCntOut), LAT_ALU);

    issueOp(6, 0, "add6");
    consumer(6, LAT_ALU, "use6");

    issueOp(5, 1, "ld5");
    chk("ld5_pend", longint'(pendingOut[5]), 1);
    consumer(5, LAT_LD, "use5");
    chk("use5_clr", longint'(pendingOut[5]), 0);

    issueOp(8, 1, "ld8");
    mcBusy = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      chk("busy_stall", longint'(stallOut), 1);
      tick();
    end
    chk("busy_pend8", longint'(pendingOut[8]), 1);
    mcBusy = 0;
    consumer(8, LAT_LD, "use8");

    idle();
    idValid = 1; regWrite = 1; memRead = 1; rd = 5'd9; flush = 1;
    @(negedge clk); #1;
    chk("flush_issue", longint'(issueOut), 0);
    tick();
    idle();
    chk("flush_pend9", longint'(pendingOut[9]), 0);

    issueOp(0, 1, "ld0");
    chk("x0_pend", longint'(pendingOut), 0);
    consumer(0, 0, "use0");

    issueOp(10, 1, "ld10");
    idValid = 1; useRs1 = 1; rs1 = 5'd10;
    @(negedge clk); #1;
    chk("mid_stall", longint'(stallOut), 1);
    rst_n = 0;
    #1;
    chk("mid_pend", longint'(pendingOut), 0);
    chk("mid_cnt", longint'(stallCntOut), 0);
    chk("mid_stall0", longint'(stallOut), 0);
    tick();
    rst_n = 1;
    @(negedge clk); #1;
    chk("rel_stall", longint'(stallOut), 0);
    chk("rel_issue", longint'(issueOut), 1);
    tick();
    idle();

    mcBusy = 1;
    repeat (70000) @(posedge clk);
    #1;
    chk("sat_cnt", longint'(stallCntOut), 64'hFFFF);
    tick();
    tick();
    chk("sat_hold", longint'(stallCntOut), 64'hFFFF);
    idle();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the pipeline's combinational stall detector. It keeps a per-register scoreboard of in-flight writes with countdown timers.
- Stalls the ID stage on RAW hazards, on a busy multi-cycle EX unit, and across variable load/writeback latency.
- Drives stall to PC/IFID/IDEX, a per-register pending mask, and a saturating stall-cycle statistic.

Parameters:
- REG_AW, 5: register address width; scoreboard covers 2**REG_AW registers. Register 0 is never tracked.
- LOAD_STALL, 1: stall cycles a consumer needs after a load issues (forwarding build).
- ALU_STALL, 0: stall cycles after a non-load write issues (forwarding build). 0 means no entry is created.
- WB_STALL, 2: stall cycles after any write issues (no-forwarding build).
- CNT_W, 16: width of the stall statistic counter.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- idValidIn  in  1  IF/ID holds a valid instruction.
- IFIDrs1In  in  REG_AW  source 1 address.
- IFIDrs2In  in  REG_AW  source 2 address.
- useRs1In  in  1  instruction reads rs1.
- useRs2In  in  1  instruction reads rs2.
- IFIDrdIn  in  REG_AW  destination address.
- IFIDRegWriteIn  in  1  instruction writes rd.
- IFIDMemReadIn  in  1  instruction is a load.
- flushIn  in  1  branch taken in EX; the ID instruction is squashed.
- mcBusyIn  in  1  multi-cycle EX unit busy; the whole pipeline freezes.
- stallOut  out  1  hold PC/IFID, bubble IDEX.
- issueOut  out  1  ID instruction enters EX this cycle.
- pendingOut  out  2**REG_AW  bit r set when cnt[r] != 0.
- stallCntOut  out  CNT_W  saturating count of cycles with stallOut=1.

Behaviour:
- State:
  - cnt[r], one per register, width clog2(max(LOAD_STALL,ALU_STALL,WB_STALL)+1).
  - stallCntOut.
- Reset: async on rst_n low. All cnt[r]=0, stallCntOut=0; therefore pendingOut=0.
  - stallOut/issueOut are combinational. With inputs low they read 0.
- Hazard (combinational):
  - hz1 = useRs1In & (IFIDrs1In!=0) & (cnt[IFIDrs1In]!=0); hz2 is the same for rs2.
- stallOut = mcBusyIn | (idValidIn & ~flushIn & (hz1|hz2)). There is no same-cycle latency from scoreboard to stall.
- issueOut = idValidIn & ~flushIn & ~stallOut.
- Per clock edge, when mcBusyIn=0:
  - every cnt[r]!=0 decrements by 1;
  - then, if issueOut & IFIDRegWriteIn & IFIDrdIn!=0, cnt[IFIDrdIn] is loaded with the latency L. L depends on build:
    - forwarding build: LOAD_STALL for loads, otherwise ALU_STALL;
    - no-forwarding build: WB_STALL.
  - Load overrides decrement on the same register; a new write to an already-pending rd replaces its count (WAW: the youngest write wins).
- When mcBusyIn=1: all cnt frozen. No issue occurs because stallOut=1.
- Flush: the squashed instruction creates no entry. Existing entries keep counting, because older producers are still in flight.
- L=0 creates no entry and leaves any existing count to decrement normally.
- rd=0 is never recorded. Sources equal to 0 never stall.
- stallCntOut increments on each edge where stallOut=1 and saturates at all-ones.
- Reset mid-stall clears everything. The first cycle after release cannot stall unless mcBusyIn=1.

Optional Feature:
- Macro: HAZARD_FORWARD_EN.
- Defined: latencies are LOAD_STALL/ALU_STALL; a load-use stalls 1 cycle and back-to-back ALU ops do not stall.
- Undefined: every write uses WB_STALL. Consumers wait until writeback, matching the earlier non-forwarding pipeline.

Test Plan:
- Forwarding build, load x5 issues, next instr uses rs1=x5 -> stallOut=1 for exactly 1 cycle, issueOut on the 2nd cycle, pendingOut[5] cleared after 1 edge.
- Forwarding build, ADD x6 then SUB using x6 -> stallOut never asserts, pendingOut[6] stays 0.
- No-forwarding build, ADD x7 then consumer of x7 -> stallOut=1 for 2 cycles, stallCntOut increases by 2.
- Load x8, mcBusyIn=1 for 4 cycles before the consumer arrives -> cnt[8] frozen at 1; consumer stalls 1 cycle after mcBusyIn drops.
- Load x9 with flushIn=1 the same cycle -> no entry, pendingOut[9]=0; write to x0 or a read of x0 never stalls.
- Assert rst_n low during a stall -> pendingOut=0, stallCntOut=0 immediately; drive stall 70000 cycles with CNT_W=16 -> stallCntOut holds 16'hFFFF.
